exc_sequencer: RTL and testbench
================================

# exc_sequencer

Multicycle exception sequencer for the MIPS-subset CPU datapath. On an invalid-opcode, arithmetic-overflow or divide-by-zero request from the main control unit, it takes over the datapath control lines and performs the full exception entry:
- computes EPC = PC − 4 through the ALU and loads the EPC register;
- reads the one-byte handler vector from the fixed exception address in memory, via the memory mux and MDR;
- loads PC with the zero-extended byte.

It sits beside the main control unit. A mux in the CPU top selects its outputs whenever `hold` is high.

## Interface
Parameters:
- `MEM_WAIT`, 1: extra cycles between address presentation and MDR capture (≥1).

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-low (0 = reset).
- `ex_opcode`, in, 1: invalid-opcode request (level).
- `ex_ovf`, in, 1: overflow request (level).
- `ex_div0`, in, 1: divide-by-zero request (level).
- `hold`, out, 1: sequencer owns datapath controls.
- `done`, out, 1: one-cycle pulse; entry complete, main control resumes at fetch.
- `cause`, out, 2: cause of the last taken exception; 0 none, 1 opcode, 2 overflow, 3 div0.
- `pc_write`, out, 1: PC register load enable.
- `mem_wr`, out, 1: memory write (0 = read); always 0 from this block.
- `mdr_load`, out, 1: MDR load enable.
- `aluout_write`, out, 1: ALUOut load enable.
- `epc_write`, out, 1: EPC load enable.
- `iord`, out, 3: memory address mux select.
- `alu_src_a`, out, 2: ALU operand A mux select.
- `alu_src_b`, out, 3: ALU operand B mux select.
- `alu_ctl`, out, 3: ALU operation.
- `pc_source`, out, 3: PC source mux select.
- `load_size`, out, 2: load-size unit select.

## Operation
- FSM states: IDLE, EPC_CALC, EPC_WR, MEM_RD, MEM_WAIT, MDR_LD, PC_LD, DONE.
- IDLE:
  - any request high at a rising edge → latch `cause` and go to EPC_CALC.
  - Priority when several requests are high together: opcode > overflow > div0.
- EPC_CALC: `alu_src_a`=SRC_A_PC, `alu_src_b`=SRC_B_FOUR, `alu_ctl`=ALU_SUB, `aluout_write`=1.
- EPC_WR: `epc_write`=1 (EPC ← ALUOut).
- MEM_RD: `iord`=`cause` (1/2/3 select the three fixed exception addresses).
  - `iord` is held at the same value through MEM_WAIT and MDR_LD.
- MEM_WAIT: counter runs MEM_WAIT cycles, then goes to MDR_LD.
- MDR_LD: `mdr_load`=1.
- PC_LD: `load_size`=LS_BYTE, `pc_source`=PCS_LS, `pc_write`=1 (PC ← zero-extended vector byte).
- DONE: `done`=1; return to IDLE next cycle.
- Requests are ignored in every state except IDLE. They are neither queued nor latched. A request still high at the IDLE edge after DONE starts a new entry.
- `hold` = (state ≠ IDLE), decoded from state. `hold` is high in DONE.
- Outside the listed assignments, every enable is 0 and every select is 0.
- `cause` holds its value until the next taken exception.
- Reset (any state, any cycle) → IDLE immediately; counter 0; `cause`=0; all outputs 0.
  - An entry interrupted by reset is abandoned: no further PC or EPC write.

## Timing
- Request sampled at edge 0. Then:
  - EPC_CALC: cycle 1.
  - EPC_WR: cycle 2.
  - MEM_RD: cycle 3.
  - MEM_WAIT: cycles 4 … 3+MEM_WAIT.
  - MDR_LD: cycle 4+MEM_WAIT.
  - PC_LD: cycle 5+MEM_WAIT.
  - DONE: cycle 6+MEM_WAIT.
- With MEM_WAIT=1, PC holds the vector after the edge ending cycle 6, and `done` is high in cycle 7.
- All outputs are Moore, decoded from registered state. There is no combinational path from the request inputs to any output.
- Counter is `$clog2(MEM_WAIT+1)` bits wide and cleared on entry to MEM_RD.

## Structure
- Package `exc_pkg` holds:
  - state enum;
  - cause codes (CAUSE_NONE/OPC/OVF/DIV0);
  - datapath select constants: IORD_PC=0; SRC_A_PC=0; SRC_B_FOUR=1; ALU_ADD=3'b001, ALU_SUB=3'b010; PCS_LS=4; LS_BYTE.
- Single module. No sub-module; the priority encoder is inline.

## Test plan
- Reset, then `ex_ovf`=1 for one cycle with MEM_WAIT=1:
  - `cause`=2;
  - `aluout_write` in cycle 1, `epc_write` in cycle 2;
  - `iord`=2 in cycles 3–5;
  - `pc_write` with `pc_source`=4 in cycle 6;
  - `done` in cycle 7;
  - `hold` high in cycles 1–7.
- `ex_opcode`=`ex_ovf`=`ex_div0`=1 in the same cycle → `cause`=1, `iord`=1.
- `ex_div0` pulsed during MEM_WAIT of an overflow entry → ignored; `cause` stays 2; single `done`.
- MEM_WAIT=3, `ex_div0` → `iord`=3 held for 5 cycles (MEM_RD, 3 × MEM_WAIT, MDR_LD); `done` at cycle 9.
- `reset`=0 asserted during MDR_LD → state IDLE, `hold`=0, `cause`=0 with no clock edge; no `pc_write` afterwards.
- `ex_ovf` held high continuously → back-to-back entries, `done` every 8 cycles (MEM_WAIT=1).

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and datapath select encodings for the exception sequencer.
package exc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EPC_CALC,
    S_EPC_WR,
    S_MEM_RD,
    S_MEM_WAIT,
    S_MDR_LD,
    S_PC_LD,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_OPC  = 2'd1,
    CAUSE_OVF  = 2'd2,
    CAUSE_DIV0 = 2'd3
  } cause_t;

  localparam logic [2:0] IORD_PC    = 3'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [2:0] SRC_B_FOUR = 3'd1;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] PCS_LS     = 3'd4;
  localparam logic [1:0] LS_BYTE    = 2'd1;

endpackage

// File: rtl/exc_sequencer.sv
// Multicycle exception entry: EPC <= PC-4, fetch the handler vector byte, PC <= vector.
module exc_sequencer
  import exc_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_opcode,
  input  logic       ex_ovf,
  input  logic       ex_div0,
  output logic       hold,
  output logic       done,
  output logic [1:0] cause,
  output logic       pc_write,
  output logic       mem_wr,
  output logic       mdr_load,
  output logic       aluout_write,
  output logic       epc_write,
  output logic [2:0] iord,
  output logic [1:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] alu_ctl,
  output logic [2:0] pc_source,
  output logic [1:0] load_size
);

  localparam int CNT_W = $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  cause_t           cause_q;
  cause_t           req_cause;
  logic             req_any;

  // Fixed priority: opcode > overflow > div0.
  always_comb begin
    req_cause = CAUSE_NONE;
    if (ex_opcode)    req_cause = CAUSE_OPC;
    else if (ex_ovf)  req_cause = CAUSE_OVF;
    else if (ex_div0) req_cause = CAUSE_DIV0;
  end

  assign req_any = ex_opcode | ex_ovf | ex_div0;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state <= state_next;
      if (state == S_IDLE && req_any) cause_q <= req_cause;
      if (state == S_EPC_WR)          cnt <= '0;
      else if (state == S_MEM_WAIT)   cnt <= cnt + CNT_W'(1);
    end
  end

  // NOTE: every output and next-state gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    hold         = 1'b1;
    done         = 1'b0;
    pc_write     = 1'b0;
    mem_wr       = 1'b0;
    mdr_load     = 1'b0;
    aluout_write = 1'b0;
    epc_write    = 1'b0;
    iord         = IORD_PC;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = 3'd0;
    alu_ctl      = 3'd0;
    pc_source    = 3'd0;
    load_size    = 2'd0;

    unique case (state)
      S_IDLE: begin
        hold = 1'b0;
        if (req_any) state_next = S_EPC_CALC;
      end
      S_EPC_CALC: begin
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_FOUR;
        alu_ctl      = ALU_SUB;
        aluout_write = 1'b1;
        state_next   = S_EPC_WR;
      end
      S_EPC_WR: begin
        epc_write  = 1'b1;
        state_next = S_MEM_RD;
      end
      S_MEM_RD: begin
        iord       = {1'b0, cause_q};
        state_next = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        iord = {1'b0, cause_q};
        if (cnt == CNT_LAST) state_next = S_MDR_LD;
      end
      S_MDR_LD: begin
        iord       = {1'b0, cause_q};
        mdr_load   = 1'b1;
        state_next = S_PC_LD;
      end
      S_PC_LD: begin
        load_size  = LS_BYTE;
        pc_source  = PCS_LS;
        pc_write   = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign cause = cause_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: two instances (MEM_WAIT=1 and 3) against a timeline model.
module tb_exc_sequencer;
  import exc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic ex_opcode, ex_ovf, ex_div0;

  always #5 clk = ~clk;

  logic hold_1, done_1, pc_write_1, mem_wr_1, mdr_load_1, aluout_write_1, epc_write_1;
  logic [1:0] cause_1, alu_src_a_1, load_size_1;
  logic [2:0] iord_1, alu_src_b_1, alu_ctl_1, pc_source_1;
  logic hold_3, done_3, pc_write_3, mem_wr_3, mdr_load_3, aluout_write_3, epc_write_3;
  logic [1:0] cause_3, alu_src_a_3, load_size_3;
  logic [2:0] iord_3, alu_src_b_3, alu_ctl_3, pc_source_3;

  exc_sequencer #(.MEM_WAIT(1)) dut_1 (
    .clk(clk), .reset(reset), .ex_opcode(ex_opcode), .ex_ovf(ex_ovf), .ex_div0(ex_div0),
    .hold(hold_1), .done(done_1), .cause(cause_1), .pc_write(pc_write_1), .mem_wr(mem_wr_1),
    .mdr_load(mdr_load_1), .aluout_write(aluout_write_1), .epc_write(epc_write_1),
    .iord(iord_1), .alu_src_a(alu_src_a_1), .alu_src_b(alu_src_b_1), .alu_ctl(alu_ctl_1),
    .pc_source(pc_source_1), .load_size(load_size_1)
  );

  exc_sequencer #(.MEM_WAIT(3)) dut_3 (
    .clk(clk), .reset(reset), .ex_opcode(ex_opcode), .ex_ovf(ex_ovf), .ex_div0(ex_div0),
    .hold(hold_3), .done(done_3), .cause(cause_3), .pc_write(pc_write_3), .mem_wr(mem_wr_3),
    .mdr_load(mdr_load_3), .aluout_write(aluout_write_3), .epc_write(epc_write_3),
    .iord(iord_3), .alu_src_a(alu_src_a_3), .alu_src_b(alu_src_b_3), .alu_ctl(alu_ctl_3),
    .pc_source(pc_source_3), .load_size(load_size_3)
  );

  wire [24:0] act_1 = {hold_1, done_1, cause_1, pc_write_1, mem_wr_1, mdr_load_1,
                       aluout_write_1, epc_write_1, iord_1, alu_src_a_1, alu_src_b_1,
                       alu_ctl_1, pc_source_1, load_size_1};
  wire [24:0] act_3 = {hold_3, done_3, cause_3, pc_write_3, mem_wr_3, mdr_load_3,
                       aluout_write_3, epc_write_3, iord_3, alu_src_a_3, alu_src_b_3,
                       alu_ctl_3, pc_source_3, load_size_3};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = cycles since the request edge (0 = idle); entry spans cycles 1 .. 6+MW.
  int         mk   [2];
  logic [1:0] mc   [2];
  int         mw   [2] = '{1, 3};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mk[i] <= 0;
        mc[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mk[i] == 0) begin
          if (ex_opcode || ex_ovf || ex_div0) begin
            mk[i] <= 1;
            mc[i] <= ex_opcode ? 2'd1 : ex_ovf ? 2'd2 : 2'd3;
          end
        end else if (mk[i] == 6 + mw[i]) begin
          mk[i] <= 0;
        end else begin
          mk[i] <= mk[i] + 1;
        end
      end
    end
  end

  function automatic logic [24:0] model_out(input int k, input int w, input logic [1:0] c);
    logic       h, d, pw, ml, aw, ew;
    logic [2:0] io, sb, ac, ps;
    logic [1:0] ls;
    h  = (k != 0);
    d  = (k == 6 + w);
    aw = (k == 1);
    sb = (k == 1) ? 3'd1 : 3'd0;
    ac = (k == 1) ? 3'b010 : 3'd0;
    ew = (k == 2);
    io = (k >= 3 && k <= 4 + w) ? {1'b0, c} : 3'd0;
    ml = (k == 4 + w);
    pw = (k == 5 + w);
    ps = pw ? 3'd4 : 3'd0;
    ls = pw ? LS_BYTE : 2'd0;
    return {h, d, c, pw, 1'b0, ml, aw, ew, io, 2'd0, sb, ac, ps, ls};
  endfunction

  always @(negedge clk) begin
    check("model_dut_mw1", {7'd0, act_1}, {7'd0, model_out(mk[0], mw[0], mc[0])});
    check("model_dut_mw3", {7'd0, act_3}, {7'd0, model_out(mk[1], mw[1], mc[1])});
  end

  // Drive a request at a negedge; return in cycle 1 of the entry.
  task automatic start(input logic opc, input logic ovf, input logic dv0);
    ex_opcode = opc; ex_ovf = ovf; ex_div0 = dv0;
    @(posedge clk);
    @(negedge clk);
    ex_opcode = 1'b0; ex_ovf = 1'b0; ex_div0 = 1'b0;
  endtask

  initial begin
    int n, dc, prev, nd;
    reset = 1'b0;
    ex_opcode = 1'b0; ex_ovf = 1'b0; ex_div0 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs_mw1", {7'd0, act_1}, 32'd0);
    check("reset_outputs_mw3", {7'd0, act_3}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single overflow entry, literal per-cycle timeline for MEM_WAIT=1.
    start(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("ovf_hold_c%0d", c), {31'd0, hold_1}, {31'd0, (c <= 7)});
      check($sformatf("ovf_aluout_c%0d", c), {31'd0, aluout_write_1}, {31'd0, (c == 1)});
      check($sformatf("ovf_epc_c%0d", c), {31'd0, epc_write_1}, {31'd0, (c == 2)});
      check($sformatf("ovf_iord_c%0d", c), {29'd0, iord_1}, (c >= 3 && c <= 5) ? 32'd2 : 32'd0);
      check($sformatf("ovf_pcsrc_c%0d", c), {28'd0, pc_write_1, pc_source_1},
            (c == 6) ? 32'hC : 32'd0);
      check($sformatf("ovf_done_c%0d", c), {31'd0, done_1}, {31'd0, (c == 7)});
      check($sformatf("ovf_cause_c%0d", c), {30'd0, cause_1}, 32'd2);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // All three requests together: opcode wins.
    start(1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("prio_cause", {30'd0, cause_1}, 32'd1);
    check("prio_iord", {29'd0, iord_1}, 32'd1);
    repeat (12) @(negedge clk);

    // div0 pulsed during MEM_WAIT of an overflow entry is ignored.
    start(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    ex_div0 = 1'b1;
    @(negedge clk);
    ex_div0 = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_1) n++;
      @(negedge clk);
    end
    check("ignore_done_count", n, 32'd1);
    check("ignore_cause_mw1", {30'd0, cause_1}, 32'd2);
    check("ignore_cause_mw3", {30'd0, cause_3}, 32'd2);
    repeat (2) @(negedge clk);

    // MEM_WAIT=3 div0 entry: iord held 5 cycles, done in cycle 9.
    start(1'b0, 1'b0, 1'b1);
    n = 0; dc = 0;
    for (int c = 1; c <= 12; c++) begin
      if (iord_3 == 3'd3) n++;
      if (done_3) dc = c;
      @(negedge clk);
    end
    check("mw3_iord_cycles", n, 32'd5);
    check("mw3_done_cycle", dc, 32'd9);
    repeat (2) @(negedge clk);

    // Asynchronous reset during MDR_LD abandons the entry.
    start(1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("rst_in_mdr_ld", {31'd0, mdr_load_1}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_hold_mw1", {31'd0, hold_1}, 32'd0);
    check("rst_cause_mw1", {30'd0, cause_1}, 32'd0);
    check("rst_hold_mw3", {31'd0, hold_3}, 32'd0);
    check("rst_all_mw1", {7'd0, act_1}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (pc_write_1 || epc_write_1) n++;
      @(negedge clk);
    end
    check("rst_no_writes_after", n, 32'd0);

    // Continuous overflow request: done every 8 cycles with MEM_WAIT=1.
    ex_ovf = 1'b1;
    prev = -1; nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_1) begin
        if (prev >= 0) check("b2b_done_interval", c - prev, 32'd8);
        prev = c;
        nd++;
      end
      @(negedge clk);
    end
    ex_ovf = 1'b0;
    check("b2b_done_count_ge4", {31'd0, (nd >= 4)}, 32'd1);
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
